// File: rtl/sd_hc_regbank.sv
// SD host-controller register bank: per-bit RW/RO/RW1C/RWAC classes, req/ack bus
// access with byte enables, hardware load/set/clear ports and a registered irq.
module sd_hc_regbank #(
    parameter int unsigned                      NUM_REGS    = 16,
    parameter int unsigned                      ADDR_W      = 4,
    parameter int unsigned                      DATA_W      = 32,
    parameter logic [NUM_REGS*DATA_W-1:0]       RW_MASK     = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]       W1C_MASK    = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]       AC_MASK     = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]       RESET_VAL   = '0,
    parameter int unsigned                      INT_STS_IDX = 12,
    parameter int unsigned                      INT_EN_IDX  = 13,
    parameter int unsigned                      INT_SIG_IDX = 14
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_req,
    input  logic                         bus_we,
    input  logic [ADDR_W-1:0]            bus_addr,
    input  logic [DATA_W-1:0]            bus_wdata,
    input  logic [DATA_W/8-1:0]          bus_be,
    output logic                         bus_ack,
    output logic [DATA_W-1:0]            bus_rdata,
    output logic                         bus_err,
    input  logic [NUM_REGS-1:0]          hw_wr_en,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_clr,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         irq
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              fire_c;
    logic              in_range_c;
    logic              wr_fire_c;
    logic [DATA_W-1:0] rd_mux_c;

    // Handshake state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one ack cycle per accepted request, requests ignored during ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus_req) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: the accepting edge is where reads capture and writes commit
    always_comb begin
        fire_c = 1'b0;
        if (state_q == ST_IDLE) begin
            fire_c = bus_req;
        end
    end

    assign bus_ack    = (state_q == ST_ACK);
    assign in_range_c = ({1'b0, bus_addr} < NUM_REGS_A);
    assign wr_fire_c  = fire_c & bus_we & in_range_c;

    always_comb begin
        rd_mux_c = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (bus_addr == ADDR_W'(r)) begin
                rd_mux_c = reg_q[r*DATA_W +: DATA_W];
            end
        end
    end

    // Bus response: rdata/err captured with the accepting edge, err is an ack-wide pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata <= '0;
            bus_err   <= 1'b0;
        end else if (fire_c) begin
            bus_rdata <= (!bus_we && in_range_c) ? rd_mux_c : '0;
            bus_err   <= !in_range_c;
        end else begin
            bus_err   <= 1'b0;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam logic [DATA_W-1:0] RW  = RW_MASK[r*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] W1C = W1C_MASK[r*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] AC  = AC_MASK[r*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] RO  = ~(RW | W1C | AC);

        logic              hit;
        logic [DATA_W-1:0] bw;
        logic [DATA_W-1:0] wset;
        logic [DATA_W-1:0] hw_val;
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] d;

        assign hit = wr_fire_c && (bus_addr == ADDR_W'(r));

        for (genvar b = 0; b < BE_W; b++) begin : g_be
            assign bw[b*8 +: 8] = {8{hit & bus_be[b]}};
        end

        assign wset   = bw & bus_wdata;
        assign hw_val = hw_wr_en[r] ? hw_wdata[r*DATA_W +: DATA_W] : q;

        // hw_set beats a bus W1C clear; a bus RWAC set beats hw_clr
        assign d = (RW  & (wset | (~bw & q)))
                 | (RO  & hw_val)
                 | (W1C & (hw_set[r*DATA_W +: DATA_W] | (q & ~wset)))
                 | (AC  & (wset | (q & ~hw_clr[r*DATA_W +: DATA_W])));

        always_ff @(posedge clk) begin
            if (reset) begin
                q <= RESET_VAL[r*DATA_W +: DATA_W];
            end else begin
                q <= d;
            end
        end

        assign reg_q[r*DATA_W +: DATA_W] = q;
    end

    // Interrupt aggregation, one cycle behind the status/enable registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(reg_q[INT_STS_IDX*DATA_W +: DATA_W]
                   & reg_q[INT_EN_IDX*DATA_W +: DATA_W]
                   & reg_q[INT_SIG_IDX*DATA_W +: DATA_W]);
        end
    end

endmodule

// File: tb/tb_sd_hc_regbank.sv
// Testbench for sd_hc_regbank: bit-level behavioural model checked every cycle,
// plus directed accesses with hand-computed expectations.
module tb_sd_hc_regbank;

    localparam int unsigned NR = 15;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned FW = NR * DW;

    localparam logic [FW-1:0] RW_M  = (FW'(32'hFFFF_FFFF) << (0*DW))  | (FW'(32'h0000_FFFF) << (3*DW))
                                    | (FW'(32'hFFFF_FFFF) << (13*DW)) | (FW'(32'hFFFF_FFFF) << (14*DW));
    localparam logic [FW-1:0] W1C_M = (FW'(32'h00FF_0000) << (3*DW))  | (FW'(32'h0000_00FF) << (12*DW));
    localparam logic [FW-1:0] AC_M  = (FW'(32'h0000_00FF) << (2*DW))  | (FW'(32'hFF00_0000) << (3*DW));
    localparam logic [FW-1:0] RST   = (FW'(32'hDEAD_BEEF) << (1*DW))  | (FW'(32'h0000_1234) << (3*DW));

    logic          clk;
    logic          reset;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [3:0]    bus_be;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          bus_err;
    logic [NR-1:0] hw_wr_en;
    logic [FW-1:0] hw_wdata;
    logic [FW-1:0] hw_set;
    logic [FW-1:0] hw_clr;
    logic [FW-1:0] reg_q;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en;

    sd_hc_regbank #(
        .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW),
        .RW_MASK(RW_M), .W1C_MASK(W1C_M), .AC_MASK(AC_M), .RESET_VAL(RST),
        .INT_STS_IDX(12), .INT_EN_IDX(13), .INT_SIG_IDX(14)
    ) dut (
        .clk(clk), .reset(reset),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .hw_wr_en(hw_wr_en), .hw_wdata(hw_wdata), .hw_set(hw_set), .hw_clr(hw_clr),
        .reg_q(reg_q), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: each bit follows the rule of its access class
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_nxt  [NR];
    logic          m_ack, m_err, m_irq, m_rd_op, m_fire, m_bw, m_wd;
    logic [DW-1:0] m_rdata;
    int            m_i;

    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NR; r++) m_regs[r] = RST[r*DW +: DW];
            m_ack = 1'b0; m_err = 1'b0; m_irq = 1'b0; m_rd_op = 1'b0; m_rdata = '0;
        end else begin
            m_fire = !m_ack && bus_req;
            for (int r = 0; r < NR; r++) begin
                m_nxt[r] = m_regs[r];
                for (int b = 0; b < DW; b++) begin
                    m_i  = r*DW + b;
                    m_bw = m_fire && bus_we && (int'(bus_addr) == r) && bus_be[b/8];
                    m_wd = bus_wdata[b];
                    if (RW_M[m_i]) begin
                        if (m_bw) m_nxt[r][b] = m_wd;
                    end else if (W1C_M[m_i]) begin
                        if (m_bw && m_wd) m_nxt[r][b] = 1'b0;
                        if (hw_set[m_i])  m_nxt[r][b] = 1'b1;
                    end else if (AC_M[m_i]) begin
                        if (hw_clr[m_i])  m_nxt[r][b] = 1'b0;
                        if (m_bw && m_wd) m_nxt[r][b] = 1'b1;
                    end else if (hw_wr_en[r]) begin
                        m_nxt[r][b] = hw_wdata[m_i];
                    end
                end
            end
            if (m_fire) begin
                m_rd_op = !bus_we;
                m_err   = (int'(bus_addr) >= NR);
                m_rdata = '0;
                for (int r = 0; r < NR; r++)
                    if (!bus_we && int'(bus_addr) == r) m_rdata = m_regs[r];
            end
            m_ack = m_fire;
            m_irq = |(m_regs[12] & m_regs[13] & m_regs[14]);
            for (int r = 0; r < NR; r++) m_regs[r] = m_nxt[r];
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack", 32'(bus_ack), 32'(m_ack));
            if (m_ack) begin
                chk("err", 32'(bus_err), 32'(m_err));
                if (m_rd_op) chk("rdata", bus_rdata, m_rdata);
            end
            chk("irq", 32'(irq), 32'(m_irq));
            for (int r = 0; r < NR; r++) chk("reg_q", reg_q[r*DW +: DW], m_regs[r]);
        end
    end

    // Drives one request starting at a negedge; hs/hc pulse only with the accepting edge
    task automatic access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [3:0] be, input logic [FW-1:0] hs, input logic [FW-1:0] hc,
                          output logic [DW-1:0] rd, output logic er, output int lat);
        bit got;
        got = 1'b0;
        rd = '0; er = 1'b0; lat = 0;
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd; bus_be = be;
        hw_set = hs; hw_clr = hc;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            hw_set = '0; hw_clr = '0;
            if (bus_ack) begin
                rd = bus_rdata; er = bus_err; lat = c; got = 1'b1;
                break;
            end
        end
        bus_req = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL ack_timeout addr=%0d: got no ack expected ack within 8 cycles", addr);
        end
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        logic [DW-1:0] rd; logic er; int lat;
        access(1'b1, addr, wd, 4'hF, '0, '0, rd, er, lat);
        @(negedge clk);
    endtask

    task automatic rdreg(input logic [AW-1:0] addr, output logic [DW-1:0] rd, output logic er);
        int lat;
        access(1'b0, addr, '0, 4'h0, '0, '0, rd, er, lat);
        @(negedge clk);
    endtask

    logic [DW-1:0] rd;
    logic          er;
    int            lat;
    int            ack_seen;

    initial begin
        reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_be = '0;
        hw_wr_en = '0; hw_wdata = '0; hw_set = '0; hw_clr = '0; chk_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_ack", 32'(bus_ack), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_r1", reg_q[1*DW +: DW], 32'hDEAD_BEEF);

        // Reset values, single-cycle latency
        for (int r = 0; r < NR; r++) begin
            access(1'b0, AW'(r), '0, 4'h0, '0, '0, rd, er, lat);
            chk("t1_rdata", rd, RST[r*DW +: DW]);
            chk("t1_err", 32'(er), 32'd0);
            chk("t1_lat", 32'(lat), 32'd1);
            @(negedge clk);
        end

        // Byte-enabled RW write
        access(1'b1, 4'd0, 32'hA5A5_A5A5, 4'b0101, '0, '0, rd, er, lat);
        @(negedge clk);
        rdreg(4'd0, rd, er);
        chk("t2_be", rd, 32'h00A5_00A5);

        // Mixed-class register: RW low half, W1C stays 0, RWAC byte sets
        wr(4'd3, 32'hFFFF_FFFF);
        rdreg(4'd3, rd, er);
        chk("t2_mixed", rd, 32'hFF00_FFFF);

        // W1C interrupt path
        wr(4'd13, 32'h8);
        wr(4'd14, 32'h8);
        hw_set = FW'(1) << (12*DW + 3);
        @(negedge clk);
        hw_set = '0;
        chk("t3_sts_set", 32'(reg_q[12*DW + 3]), 32'd1);
        chk("t3_irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t3_irq_on", 32'(irq), 32'd1);
        access(1'b1, 4'd12, 32'h8, 4'hF, '0, '0, rd, er, lat);
        chk("t3_sts_clr", 32'(reg_q[12*DW + 3]), 32'd0);
        chk("t3_irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("t3_irq_off", 32'(irq), 32'd0);
        access(1'b1, 4'd12, 32'h8, 4'hF, FW'(1) << (12*DW + 3), '0, rd, er, lat);
        chk("t3_set_wins", 32'(reg_q[12*DW + 3]), 32'd1);
        @(negedge clk);
        chk("t3_irq_again", 32'(irq), 32'd1);

        // RWAC bit
        wr(4'd2, 32'h2);
        chk("t4_set", reg_q[2*DW +: DW], 32'h2);
        repeat (5) @(negedge clk);
        chk("t4_hold", reg_q[2*DW +: DW], 32'h2);
        hw_clr = FW'(1) << (2*DW + 1);
        @(negedge clk);
        hw_clr = '0;
        chk("t4_clr", reg_q[2*DW +: DW], 32'h0);
        access(1'b1, 4'd2, 32'h2, 4'hF, '0, FW'(1) << (2*DW + 1), rd, er, lat);
        chk("t4_bus_wins", reg_q[2*DW +: DW], 32'h2);
        @(negedge clk);

        // Fully RO register
        wr(4'd1, 32'hFFFF_FFFF);
        rdreg(4'd1, rd, er);
        chk("t5_ro_keep", rd, 32'hDEAD_BEEF);
        hw_wr_en = NR'(1) << 1;
        hw_wdata = FW'(32'h1234) << DW;
        @(negedge clk);
        hw_wr_en = '0;
        hw_wdata = '0;
        rdreg(4'd1, rd, er);
        chk("t5_ro_load", rd, 32'h0000_1234);

        // Out-of-range accesses
        access(1'b0, 4'd15, '0, 4'h0, '0, '0, rd, er, lat);
        chk("t6_rd_err", 32'(er), 32'd1);
        chk("t6_rd_zero", rd, 32'h0);
        @(negedge clk);
        access(1'b1, 4'd15, 32'hFFFF_FFFF, 4'hF, '0, '0, rd, er, lat);
        chk("t6_wr_err", 32'(er), 32'd1);
        @(negedge clk);
        rdreg(4'd0, rd, er);
        chk("t6_no_change", rd, 32'h00A5_00A5);

        // Reset while a request is pending
        ack_seen = 0;
        reset = 1'b1; bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'd0;
        bus_wdata = 32'hFFFF_FFFF; bus_be = 4'hF;
        repeat (3) begin
            @(negedge clk);
            if (bus_ack) ack_seen++;
        end
        reset = 1'b0; bus_req = 1'b0;
        @(negedge clk);
        if (bus_ack) ack_seen++;
        chk("t6_rst_noack", 32'(ack_seen), 32'd0);
        chk("t6_rst_irq", 32'(irq), 32'd0);
        for (int r = 0; r < NR; r++) chk("t6_rst_val", reg_q[r*DW +: DW], RST[r*DW +: DW]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
